la_sram_req_ctrl: RTL and testbench

//  Request/response front-end for the single-port SRAM1RW64x128 macro.

---
 rtl/la_sram_pkg.sv | 12 +
 rtl/SRAM1RW64x128.sv | 26 ++
 rtl/la_sram_rsp_fifo.sv | 60 ++++++
 rtl/la_sram_req_ctrl.sv | 122 ++++++++++++
 tb/tb_la_sram_req_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/la_sram_pkg.sv
// Shared types and default sizes for the SRAM1RW64x128 request front-end.
package la_sram_pkg;

    localparam int LA_AW = 6;
    localparam int LA_DW = 128;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/SRAM1RW64x128.sv
// Behavioural model of the single-port 64x128 macro: synchronous write/read on CE,
// read data held in an output register and driven only while OEB is low.
module SRAM1RW64x128 (
    input  logic         CE,
    input  logic         CSB,
    input  logic         WEB,
    input  logic         OEB,
    input  logic [5:0]   A,
    input  logic [127:0] I,
    output logic [127:0] O
);

    logic [127:0] mem [64];
    logic [127:0] o_q;

    // Array write or registered read on every selected clock edge.
    always_ff @(posedge CE) begin
        if (!CSB) begin
            if (!WEB) mem[A] <= I;
            else      o_q    <= mem[A];
        end
    end

    assign O = OEB ? '0 : o_q;

endmodule

// File: rtl/la_sram_rsp_fifo.sv
// Small response FIFO: registered storage, head word presented directly,
// explicit occupancy count used by the request side for slot reservation.
module la_sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 128,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Upstream reservation guarantees these never happen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(pop && count == '0));
            assert (!(push && !pop && count == CW'(DEPTH)));
        end
    end

    assign valid = (count != '0);
    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/la_sram_req_ctrl.sv
// Valid/ready front-end for SRAM1RW64x128: clears the array after reset, then maps
// accepted requests onto macro strobes and queues read data for the consumer.
module la_sram_req_ctrl
    import la_sram_pkg::*;
#(
    parameter int            AW        = LA_AW,
    parameter int            DW        = LA_DW,
    parameter int            RSP_DEPTH = 2,
    parameter bit            INIT_EN   = 1'b1,
    parameter logic [DW-1:0] INIT_VAL  = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic [AW-1:0] sram_A,
    output logic [DW-1:0] sram_I,
    input  logic [DW-1:0] sram_O,
    output logic          sram_CSB,
    output logic          sram_WEB,
    output logic          sram_OEB
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(RSP_DEPTH + 1);

    state_e        state_q, state_d;
    logic [AW:0]   init_ptr;
    logic          init_last;
    logic          rd_inflight;
    logic          init_done_q;
    logic          req_fire;
    logic          rsp_pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   outstanding;

    assign init_last = (init_ptr == (AW + 1)'(DEPTH - 1));
    assign req_fire  = req_valid && req_ready;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Reads already in the macro pipeline or sitting in the FIFO each own a slot.
    // A popping head still counts this cycle, so ready depends on registered state only.
    assign outstanding = {1'b0, fifo_count} + (CW + 1)'(rd_inflight);
    assign req_ready   = (state_q == ST_RUN) &&
                         (req_we || outstanding < (CW + 1)'(RSP_DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT_EN ? ST_INIT : ST_RUN;
        else     state_q <= state_d;
    end

    // Next state and macro strobes; idle leaves the macro deselected.
    always_comb begin
        state_d  = state_q;
        sram_CSB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_I   = '0;
        case (state_q)
            ST_INIT: begin
                sram_CSB = 1'b0;
                sram_WEB = 1'b0;
                sram_A   = init_ptr[AW-1:0];
                sram_I   = INIT_VAL;
                if (init_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (req_fire) begin
                    sram_CSB = 1'b0;
                    sram_WEB = ~req_we;
                    sram_A   = req_addr;
                    sram_I   = req_wdata;
                end
            end
        endcase
    end

    // Init sweep pointer; parks at DEPTH once the sweep is over.
    always_ff @(posedge clk) begin
        if (rst)                     init_ptr <= '0;
        else if (state_q == ST_INIT) init_ptr <= init_ptr + 1'b1;
    end

    // Marks the cycle after a read was issued, when the macro output is live.
    always_ff @(posedge clk) begin
        if (rst) rd_inflight <= 1'b0;
        else     rd_inflight <= req_fire && !req_we;
    end

    // Sticky completion flag, raised together with the move into RUN.
    always_ff @(posedge clk) begin
        if (rst)                    init_done_q <= 1'b0;
        else if (state_d == ST_RUN) init_done_q <= 1'b1;
    end

    assign init_done = init_done_q;
    assign sram_OEB  = ~rd_inflight;

    la_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DW),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_inflight),
        .wdata (sram_O),
        .pop   (rsp_pop),
        .rdata (rsp_rdata),
        .valid (rsp_valid),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_la_sram_req_ctrl.sv
// Bench for la_sram_req_ctrl with the SRAM1RW64x128 model; a cycle-level
// reference of the request/response contract checks every cycle.
module tb_la_sram_req_ctrl;

    localparam int AW        = 6;
    localparam int DW        = 128;
    localparam int RSP_DEPTH = 2;
    localparam int INIT_CYC  = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_I, sram_O;
    logic          sram_CSB, sram_WEB, sram_OEB;

    always #5 clk = ~clk;

    la_sram_req_ctrl #(
        .AW(AW), .DW(DW), .RSP_DEPTH(RSP_DEPTH), .INIT_EN(1'b1), .INIT_VAL('0)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .sram_A(sram_A), .sram_I(sram_I), .sram_O(sram_O),
        .sram_CSB(sram_CSB), .sram_WEB(sram_WEB), .sram_OEB(sram_OEB)
    );

    SRAM1RW64x128 u_sram (
        .CE(clk), .CSB(sram_CSB), .WEB(sram_WEB), .OEB(sram_OEB),
        .A(sram_A), .I(sram_I), .O(sram_O)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: array contents, reads owed to the consumer with the first cycle
    // each may be presented, and the number of cycles since reset released.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } rsp_t;

    logic [DW-1:0] mdl_mem [1 << AW];
    rsp_t          exp_q [$];
    int            cyc     = 0;
    int            post    = 0;
    bit            started = 1'b0;

    always @(negedge clk) begin
        logic exp_rdy, exp_vld;
        rsp_t e;
        cyc++;
        if (rst) begin
            started = 1'b1;
            post    = -1;
            exp_q.delete();
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
        end else if (started) begin
            post++;
            exp_rdy = (post >= INIT_CYC) && (req_we || exp_q.size() < RSP_DEPTH);
            exp_vld = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            check("init_done", DW'(init_done), DW'(post >= INIT_CYC));
            check("req_ready", DW'(req_ready), DW'(exp_rdy));
            check("rsp_valid", DW'(rsp_valid), DW'(exp_vld));
            if (exp_vld && rsp_ready) begin
                check("rsp_rdata", rsp_rdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (req_valid && exp_rdy) begin
                if (req_we) begin
                    mdl_mem[req_addr] = req_wdata;
                end else begin
                    e.data  = mdl_mem[req_addr];
                    e.avail = cyc + 2;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (w >= 200) check("req_timeout", DW'(req_ready), DW'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int w = 0;
        while (!init_done && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("init_wait", DW'(init_done), DW'(1));
    endtask

    initial begin
        int n;
        logic [DW-1:0] pat;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Init takes exactly one cycle per word.
        n = 0;
        @(negedge clk);
        while (!init_done && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("init_lat", DW'(n), DW'(INIT_CYC));
        @(posedge clk); #1;

        // Whole array reads back as the init value.
        for (int a = 0; a < (1 << AW); a++) do_req(1'b0, AW'(a), '0);
        idle(6);

        // Write then read, with the two-cycle response latency checked directly.
        pat = {16{8'hA5}};
        do_req(1'b1, 6'd5, pat);
        do_req(1'b0, 6'd5, '0);
        @(negedge clk);
        check("lat_n1_valid", DW'(rsp_valid), DW'(0));
        @(negedge clk);
        check("lat_n2_valid", DW'(rsp_valid), DW'(1));
        check("lat_n2_data", rsp_rdata, pat);
        @(posedge clk); #1;
        idle(4);

        // Backpressure: only two reads can be reserved.
        rsp_ready = 1'b0;
        do_req(1'b0, 6'd1, '0);
        do_req(1'b0, 6'd5, '0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd2;
        repeat (3) begin
            @(negedge clk);
            check("blk_ready", DW'(req_ready), DW'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        do_req(1'b0, 6'd2, '0);
        idle(6);

        // Streaming reads, in order.
        for (int a = 0; a < 16; a++) do_req(1'b0, AW'(a), '0);
        idle(6);

        // Read/write hazards on one address.
        do_req(1'b1, 6'd9, {$urandom, $urandom, $urandom, $urandom});
        do_req(1'b0, 6'd9, '0);
        do_req(1'b1, 6'd9, DW'(1));
        do_req(1'b0, 6'd9, '0);
        idle(6);

        // Reset with one response queued and one read in flight.
        rsp_ready = 1'b0;
        do_req(1'b0, 6'd5, '0);
        do_req(1'b0, 6'd9, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
        check("rst_init_done", DW'(init_done), DW'(0));
        @(posedge clk); #1;
        wait_init();
        idle(2);

        // Random traffic over a narrow address range, with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            rst       = (i == 700);
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom_range(0, 7));
            req_wdata = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        idle(10);
        check("drain", DW'(exp_q.size()), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
